score_char_writer: RTL and testbench
====================================

SCORE_CHAR_WRITER -- requirements
Module: score_char_writer

Interface
REQ-001 The parameter P1_ADDR SHALL default to 12'h05C and gives the text-RAM address of player-1 tens digit; units digit is at P1_ADDR+1.
REQ-002 The parameter P2_ADDR SHALL default to 12'h06B and gives the text-RAM address of player-2 tens digit; units digit is at P2_ADDR+1.
REQ-003 The parameter WR_LOW_CYCLES SHALL default to 1 and gives the number of cycles oChar_nWr is held low per write; legal range is 1..15.
REQ-004 Port iVGA_CLK SHALL be an input, 1 bit wide: pixel clock, all logic rising-edge.
REQ-005 Port iRST_n SHALL be an input, 1 bit wide: reset, asynchronous, active-low.
REQ-006 Port iP1Score SHALL be an input, 4 bits wide: player-1 score, 0..15.
REQ-007 Port iP2Score SHALL be an input, 4 bits wide: player-2 score, 0..15.
REQ-008 Port iRefresh SHALL be an input, 1 bit wide: single-cycle request to rewrite both scores even if they are unchanged.
REQ-009 Port oCharAddr SHALL be an output, 12 bits wide: text-RAM write address.
REQ-010 Port oCharData SHALL be an output, 8 bits wide: ASCII character to write.
REQ-011 Port oChar_nWr SHALL be an output, 1 bit wide: active-low write strobe.
REQ-012 Port oBusy SHALL be an output, 1 bit wide: high while a write sequence is in progress.

Function
REQ-013 The block SHALL hold shadow registers sh1/sh2, which store the last scores written, plus a dirty flag.
REQ-014 States SHALL be IDLE, SETUP, STROBE, HOLD and a 2-bit write index widx (0..3).
REQ-015 In IDLE, when dirty=1, iP1Score!=sh1 or iP2Score!=sh2, the next edge SHALL do all of the following: sh1<=iP1Score, sh2<=iP2Score, dirty<=0, widx<=0, state<=SETUP, oBusy<=1.
REQ-016 Write order SHALL be: widx0 = P1 tens at P1_ADDR, widx1 = P1 units at P1_ADDR+1, widx2 = P2 tens at P2_ADDR, widx3 = P2 units at P2_ADDR+1.
REQ-017 Digits SHALL be formed from the shadow registers only. Tens digit = (sh>=10) ? 8'h31 : 8'h30. Units digit = 8'h30 + (sh>=10 ? sh-10 : sh).
REQ-018 In SETUP, oCharAddr and oCharData SHALL be driven and oChar_nWr=1 for exactly 1 cycle, then the state SHALL go to STROBE.
REQ-019 In STROBE, oChar_nWr SHALL be 0 for exactly WR_LOW_CYCLES cycles, with address and data stable; the state SHALL then go to HOLD.
REQ-020 In HOLD, oChar_nWr=1 with address and data stable for 1 cycle. If widx<3, widx SHALL increment and the state SHALL go to SETUP; otherwise the state SHALL go to IDLE with oBusy<=0.
REQ-021 A full sequence SHALL last 4*(2+WR_LOW_CYCLES) cycles, which is 12 cycles at the default; oBusy SHALL be high for exactly that many cycles.
REQ-022 Score inputs changing while oBusy=1 SHALL NOT alter the writes in flight; IDLE detects the difference and starts a new sequence one cycle after the previous one completes.
REQ-023 iRefresh=1 in any state SHALL set dirty; if oBusy=1, exactly one further sequence SHALL follow the current one.
REQ-024 iRefresh coinciding with the IDLE-exit edge SHALL leave dirty=1, so exactly one extra sequence follows.
REQ-025 oChar_nWr SHALL never go low outside STROBE, and oCharAddr/oCharData SHALL never change while oChar_nWr=0.

Reset
REQ-026 iRST_n=0 SHALL asynchronously force: state=IDLE, widx=0, sh1=0, sh2=0, dirty=1, oCharAddr=12'h000, oCharData=8'h20, oChar_nWr=1, oBusy=0.
REQ-027 Reset asserted mid-sequence SHALL abort the sequence immediately with oChar_nWr=1; no partial strobe SHALL follow deassertion.
REQ-028 Because dirty=1 out of reset, the first sequence SHALL start on the second rising edge after reset deassertion.

Configuration
REQ-029 With macro SCORE_LEADING_BLANK_EN defined, a tens digit of zero (sh<10) SHALL be written as 8'h20 (space); all other behaviour SHALL be unchanged.
REQ-030 With SCORE_LEADING_BLANK_EN undefined, a tens digit of zero SHALL be written as 8'h30 ('0').

Verification
REQ-031 Scenario: release reset with P1=0, P2=0 -> four writes (05C,30),(05D,30),(06B,30),(06C,30) occur, oBusy is high for 12 cycles, and each nWr low pulse is 1 cycle.
REQ-032 Scenario: from idle, set P1=12 -> sequence writes (05C,31),(05D,32),(06B,30),(06C,30); with SCORE_LEADING_BLANK_EN the P2 tens write is 20.
REQ-033 Scenario: change P2 from 3 to 4 during the second write -> the first sequence writes P2 '3', then a second sequence starts 1 cycle after oBusy falls and writes '4' at 06C.
REQ-034 Scenario: pulse iRefresh twice during one sequence with scores unchanged -> exactly one extra 12-cycle sequence follows with identical data.
REQ-035 Scenario: assert reset during STROBE of widx2 -> oChar_nWr=1 and oBusy=0 immediately; after release, a full sequence is written from widx0.
REQ-036 Scenario: WR_LOW_CYCLES=3 with P1=15 -> nWr low pulses are 3 cycles, data (05C,31),(05D,35), oBusy is high for 20 cycles, and address/data are stable while nWr=0.

Source files
------------

// File: rtl/score_char_writer.sv
// score_char_writer
// Writes the two player scores as two ASCII digits each into a text RAM.
// When a score differs from the last value written, or a refresh has been
// requested, the block runs four writes in order: P1 tens, P1 units,
// P2 tens, P2 units. Each write is SETUP (address/data valid, strobe high),
// STROBE (strobe low for WR_LOW_CYCLES cycles), HOLD (strobe high again).
//
// Ports
//   iVGA_CLK   pixel clock, rising edge
//   iRST_n     asynchronous active-low reset
//   iP1Score   player-1 score, 0..15
//   iP2Score   player-2 score, 0..15
//   iRefresh   single-cycle request to rewrite both scores
//   oCharAddr  text-RAM write address
//   oCharData  ASCII character
//   oChar_nWr  active-low write strobe
//   oBusy      high while a write sequence is running
//
// Build option
//   SCORE_LEADING_BLANK_EN  when defined, a zero tens digit is written as a
//                           space instead of '0'.
//
// state  | meaning
// IDLE   | waiting for a score change or pending refresh
// SETUP  | address/data presented, strobe high, 1 cycle
// STROBE | strobe low for WR_LOW_CYCLES cycles
// HOLD   | strobe high, address/data held, 1 cycle; next write or done

module score_char_writer #(
   parameter logic [11:0] P1_ADDR       = 12'h05C,
   parameter logic [11:0] P2_ADDR       = 12'h06B,
   parameter int unsigned WR_LOW_CYCLES = 1
) (
   input  logic        iVGA_CLK,
   input  logic        iRST_n,
   input  logic [3:0]  iP1Score,
   input  logic [3:0]  iP2Score,
   input  logic        iRefresh,
   output logic [11:0] oCharAddr,
   output logic [7:0]  oCharData,
   output logic        oChar_nWr,
   output logic        oBusy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } state_t;

   localparam logic [3:0] STROBE_LOAD = 4'(WR_LOW_CYCLES - 1);

`ifdef SCORE_LEADING_BLANK_EN
   localparam logic [7:0] ZERO_TENS = 8'h20;
`else
   localparam logic [7:0] ZERO_TENS = 8'h30;
`endif

   state_t      state_q, state_d;
   logic [1:0]  widx_q, widx_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  sh1_q, sh1_d;
   logic [3:0]  sh2_q, sh2_d;
   logic        dirty_q, dirty_d;
   logic        armed_q, armed_d;
   logic [11:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        nwr_q, nwr_d;
   logic        busy_q, busy_d;

   function automatic logic [7:0] tens_char(input logic [3:0] sc);
      logic [7:0] c;
      if (sc >= 4'd10) c = 8'h31;
      else             c = ZERO_TENS;
      return c;
   endfunction

   function automatic logic [7:0] units_char(input logic [3:0] sc);
      logic [3:0] u;
      if (sc >= 4'd10) u = sc - 4'd10;
      else             u = sc;
      return 8'h30 + {4'h0, u};
   endfunction

   function automatic logic [11:0] slot_addr(input logic [1:0] idx);
      logic [11:0] a;
      case (idx)
         2'd0:    a = P1_ADDR;
         2'd1:    a = P1_ADDR + 12'd1;
         2'd2:    a = P2_ADDR;
         default: a = P2_ADDR + 12'd1;
      endcase
      return a;
   endfunction

   function automatic logic [7:0] slot_data(input logic [1:0] idx,
                                            input logic [3:0] s1,
                                            input logic [3:0] s2);
      logic [7:0] d;
      case (idx)
         2'd0:    d = tens_char(s1);
         2'd1:    d = units_char(s1);
         2'd2:    d = tens_char(s2);
         default: d = units_char(s2);
      endcase
      return d;
   endfunction

   always_comb begin
      state_d = state_q;
      widx_d  = widx_q;
      cnt_d   = cnt_q;
      sh1_d   = sh1_q;
      sh2_d   = sh2_q;
      dirty_d = dirty_q | iRefresh;
      // One idle edge after reset release before the first sequence may start.
      armed_d = 1'b1;
      addr_d  = addr_q;
      data_d  = data_q;
      nwr_d   = nwr_q;
      busy_d  = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (armed_q && (dirty_q || iP1Score != sh1_q || iP2Score != sh2_q)) begin
               sh1_d   = iP1Score;
               sh2_d   = iP2Score;
               // A refresh on this very edge is not consumed by this sequence.
               dirty_d = iRefresh;
               widx_d  = 2'd0;
               state_d = ST_SETUP;
               busy_d  = 1'b1;
               // Outputs are registered, so the first slot is built from the
               // values being captured into the shadows on this edge.
               addr_d  = slot_addr(2'd0);
               data_d  = slot_data(2'd0, iP1Score, iP2Score);
            end
         end
         ST_SETUP: begin
            state_d = ST_STROBE;
            nwr_d   = 1'b0;
            cnt_d   = STROBE_LOAD;
         end
         ST_STROBE: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_HOLD;
               nwr_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            if (widx_q != 2'd3) begin
               widx_d  = widx_q + 2'd1;
               state_d = ST_SETUP;
               addr_d  = slot_addr(widx_q + 2'd1);
               data_d  = slot_data(widx_q + 2'd1, sh1_q, sh2_q);
            end else begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            nwr_d   = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q <= ST_IDLE;
         widx_q  <= 2'd0;
         cnt_q   <= 4'd0;
         sh1_q   <= 4'd0;
         sh2_q   <= 4'd0;
         dirty_q <= 1'b1;
         armed_q <= 1'b0;
         addr_q  <= 12'h000;
         data_q  <= 8'h20;
         nwr_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         widx_q  <= widx_d;
         cnt_q   <= cnt_d;
         sh1_q   <= sh1_d;
         sh2_q   <= sh2_d;
         dirty_q <= dirty_d;
         armed_q <= armed_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         nwr_q   <= nwr_d;
         busy_q  <= busy_d;
      end
   end

   assign oCharAddr = addr_q;
   assign oCharData = data_q;
   assign oChar_nWr = nwr_q;
   assign oBusy     = busy_q;

endmodule

// File: tb/tb_score_char_writer.sv
module tb_score_char_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  p1, p2;
   logic        refresh;
   logic [11:0] addr, addr3;
   logic [7:0]  data, data3;
   logic        nwr, nwr3;
   logic        busy, busy3;

   always #5 clk = ~clk;

   score_char_writer u_dut (
      .iVGA_CLK (clk),
      .iRST_n   (rst_n),
      .iP1Score (p1),
      .iP2Score (p2),
      .iRefresh (refresh),
      .oCharAddr(addr),
      .oCharData(data),
      .oChar_nWr(nwr),
      .oBusy    (busy)
   );

   score_char_writer #(.WR_LOW_CYCLES(3)) u_dut3 (
      .iVGA_CLK (clk),
      .iRST_n   (rst_n),
      .iP1Score (p1),
      .iP2Score (p2),
      .iRefresh (refresh),
      .oCharAddr(addr3),
      .oCharData(data3),
      .oChar_nWr(nwr3),
      .oBusy    (busy3)
   );

   int errors = 0;
   int checks = 0;
   int cur_p1 = 0;
   int cur_p2 = 0;

   // Reference: digit k of a score pair, as {address, character}.
   function automatic logic [19:0] exp_write(input int s1, input int s2, input int k);
      int          sc;
      int          digit;
      logic [11:0] base;
      logic [7:0]  ch;
      sc   = (k < 2) ? s1 : s2;
      base = (k < 2) ? 12'h05C : 12'h06B;
      if (k % 2 == 0) begin
         digit = sc / 10;
         ch    = 8'(48 + digit);
`ifdef SCORE_LEADING_BLANK_EN
         if (digit == 0) ch = 8'h20;
`endif
         return {base, ch};
      end
      digit = sc % 10;
      return {base + 12'd1, 8'(48 + digit)};
   endfunction

   // Monitor of the default-parameter instance, sampled on falling edges.
   logic [19:0] wr_q[$];
   int          len_q[$];
   int          busy_q[$];
   int          rise_q[$];
   int          fall_q[$];
   int          stab_viol = 0;
   int          cyc = 0;
   int          low_run = 0;
   int          busy_run = 0;
   logic        prev_nwr = 1'b1;
   logic        prev_busy = 1'b0;
   logic [19:0] cap;

   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         prev_nwr  = 1'b1;
         prev_busy = 1'b0;
         busy_run  = 0;
         low_run   = 0;
      end else begin
         if (!nwr) begin
            if (prev_nwr) begin
               wr_q.push_back({addr, data});
               cap     = {addr, data};
               low_run = 1;
            end else begin
               low_run++;
               if ({addr, data} !== cap) stab_viol++;
            end
            if (!busy) stab_viol++;
         end else if (!prev_nwr) begin
            len_q.push_back(low_run);
         end
         if (busy) begin
            busy_run++;
            if (!prev_busy) rise_q.push_back(cyc);
         end else if (prev_busy) begin
            busy_q.push_back(busy_run);
            fall_q.push_back(cyc);
            busy_run = 0;
         end
         prev_nwr  = nwr;
         prev_busy = busy;
      end
   end

   task automatic clear_mon();
      wr_q.delete();
      len_q.delete();
      busy_q.delete();
      rise_q.delete();
      fall_q.delete();
      stab_viol = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; p1 = 4'd0; p2 = 4'd0; refresh = 1'b0;
      cur_p1 = 0; cur_p2 = 0;
      repeat (3) @(negedge clk);
      checks++; if (addr !== 12'h000) begin errors++; $display("FAIL reset_addr: got %h expected 000", addr); end
      checks++; if (data !== 8'h20) begin errors++; $display("FAIL reset_data: got %h expected 20", data); end
      checks++; if (nwr !== 1'b1) begin errors++; $display("FAIL reset_nwr: got %b expected 1", nwr); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      clear_mon();
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_edge1: busy %b expected 0", busy); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_edge2: busy %b expected 1", busy); end
      repeat (20) @(negedge clk);
      checks++; if (wr_q.size() !== 4) begin errors++; $display("FAIL reset_nwrites: got %0d expected 4", wr_q.size()); end
      for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
         checks++;
         if (wr_q[k] !== exp_write(0, 0, k)) begin errors++; $display("FAIL reset_write%0d: got %h expected %h", k, wr_q[k], exp_write(0, 0, k)); end
      end
      foreach (len_q[k]) begin
         checks++; if (len_q[k] !== 1) begin errors++; $display("FAIL reset_pulse%0d: got %0d expected 1", k, len_q[k]); end
      end
      checks++; if (busy_q.size() !== 1 || busy_q[0] !== 12) begin errors++; $display("FAIL reset_busylen: got %0d runs first %0d expected 1 run of 12", busy_q.size(), (busy_q.size() > 0) ? busy_q[0] : -1); end
      checks++; if (stab_viol !== 0) begin errors++; $display("FAIL reset_stability: got %0d violations expected 0", stab_viol); end
   endtask

   task automatic test_p1_12();
      clear_mon();
      @(negedge clk); p1 = 4'd12; cur_p1 = 12;
      repeat (20) @(negedge clk);
      checks++; if (wr_q.size() !== 4) begin errors++; $display("FAIL p1_12_nwrites: got %0d expected 4", wr_q.size()); end
      for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
         checks++;
         if (wr_q[k] !== exp_write(12, cur_p2, k)) begin errors++; $display("FAIL p1_12_write%0d: got %h expected %h", k, wr_q[k], exp_write(12, cur_p2, k)); end
      end
   endtask

   task automatic test_random();
      int np1, np2;
      for (int it = 0; it < 8; it++) begin
         clear_mon();
         np1 = int'($urandom_range(0, 15));
         np2 = int'($urandom_range(0, 15));
         @(negedge clk);
         p1 = 4'(np1); p2 = 4'(np2);
         refresh = (np1 == cur_p1 && np2 == cur_p2);
         cur_p1 = np1; cur_p2 = np2;
         @(negedge clk); refresh = 1'b0;
         repeat (20) @(negedge clk);
         checks++; if (wr_q.size() !== 4) begin errors++; $display("FAIL rand%0d_nwrites: got %0d expected 4", it, wr_q.size()); end
         for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
            checks++;
            if (wr_q[k] !== exp_write(np1, np2, k)) begin errors++; $display("FAIL rand%0d_write%0d: got %h expected %h", it, k, wr_q[k], exp_write(np1, np2, k)); end
         end
         checks++; if (busy_q.size() !== 1 || busy_q[0] !== 12) begin errors++; $display("FAIL rand%0d_busy: got %0d runs first %0d expected 1 run of 12", it, busy_q.size(), (busy_q.size() > 0) ? busy_q[0] : -1); end
         checks++; if (stab_viol !== 0) begin errors++; $display("FAIL rand%0d_stability: got %0d expected 0", it, stab_viol); end
      end
   endtask

   task automatic test_change_during_busy();
      int np1;
      @(negedge clk); p2 = 4'd3; cur_p2 = 3;
      repeat (20) @(negedge clk);
      clear_mon();
      np1 = (cur_p1 + 5) % 16;
      p1 = 4'(np1); cur_p1 = np1;
      repeat (5) @(negedge clk);
      p2 = 4'd4; cur_p2 = 4;
      repeat (40) @(negedge clk);
      checks++; if (wr_q.size() !== 8) begin errors++; $display("FAIL midchg_nwrites: got %0d expected 8", wr_q.size()); end
      for (int k = 0; k < 8 && k < wr_q.size(); k++) begin
         checks++;
         if (wr_q[k] !== exp_write(np1, (k < 4) ? 3 : 4, k % 4)) begin errors++; $display("FAIL midchg_write%0d: got %h expected %h", k, wr_q[k], exp_write(np1, (k < 4) ? 3 : 4, k % 4)); end
      end
      checks++;
      if (rise_q.size() < 2 || fall_q.size() < 1 || rise_q[1] - fall_q[0] !== 1) begin
         errors++; $display("FAIL midchg_gap: rises %0d falls %0d expected second start 1 cycle after busy falls", rise_q.size(), fall_q.size());
      end
   endtask

   task automatic test_refresh();
      // Single refresh in idle with unchanged scores: one sequence.
      clear_mon();
      @(negedge clk); refresh = 1'b1;
      @(negedge clk); refresh = 1'b0;
      repeat (25) @(negedge clk);
      checks++; if (busy_q.size() !== 1) begin errors++; $display("FAIL refresh_idle_seqs: got %0d expected 1", busy_q.size()); end
      checks++; if (wr_q.size() !== 4) begin errors++; $display("FAIL refresh_idle_nwrites: got %0d expected 4", wr_q.size()); end
      // Refresh on the same edge that starts a sequence: one extra sequence.
      clear_mon();
      @(negedge clk); cur_p1 = (cur_p1 + 1) % 16; p1 = 4'(cur_p1); refresh = 1'b1;
      @(negedge clk); refresh = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if (busy_q.size() !== 2) begin errors++; $display("FAIL refresh_exit_seqs: got %0d expected 2", busy_q.size()); end
      for (int k = 0; k < 8 && k < wr_q.size(); k++) begin
         checks++;
         if (wr_q[k] !== exp_write(cur_p1, cur_p2, k % 4)) begin errors++; $display("FAIL refresh_exit_write%0d: got %h expected %h", k, wr_q[k], exp_write(cur_p1, cur_p2, k % 4)); end
      end
      // Two refresh pulses during a sequence: exactly one extra sequence.
      clear_mon();
      @(negedge clk); cur_p1 = (cur_p1 + 3) % 16; p1 = 4'(cur_p1);
      repeat (3) @(negedge clk);
      refresh = 1'b1; @(negedge clk); refresh = 1'b0;
      repeat (3) @(negedge clk);
      refresh = 1'b1; @(negedge clk); refresh = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if (busy_q.size() !== 2) begin errors++; $display("FAIL refresh_twice_seqs: got %0d expected 2", busy_q.size()); end
      checks++; if (wr_q.size() !== 8) begin errors++; $display("FAIL refresh_twice_nwrites: got %0d expected 8", wr_q.size()); end
      for (int k = 0; k < 8 && k < wr_q.size(); k++) begin
         checks++;
         if (wr_q[k] !== exp_write(cur_p1, cur_p2, k % 4)) begin errors++; $display("FAIL refresh_twice_write%0d: got %h expected %h", k, wr_q[k], exp_write(cur_p1, cur_p2, k % 4)); end
      end
      foreach (busy_q[k]) begin
         checks++; if (busy_q[k] !== 12) begin errors++; $display("FAIL refresh_twice_busy%0d: got %0d expected 12", k, busy_q[k]); end
      end
   endtask

   task automatic test_reset_mid();
      int   falls = 0;
      logic prev = 1'b1;
      logic found = 1'b0;
      @(negedge clk); cur_p1 = (cur_p1 + 7) % 16; p1 = 4'(cur_p1);
      for (int c = 0; c < 30 && !found; c++) begin
         @(posedge clk); #1;
         if (!nwr && prev) falls++;
         prev = nwr;
         if (falls == 3 && !nwr) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL midrst_reach: third strobe seen %0d expected 1", found); end
      rst_n = 1'b0;
      #1;
      checks++; if (nwr !== 1'b1) begin errors++; $display("FAIL midrst_nwr: got %b expected 1", nwr); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      @(negedge clk);
      clear_mon();
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      checks++; if (wr_q.size() !== 4) begin errors++; $display("FAIL midrst_nwrites: got %0d expected 4", wr_q.size()); end
      for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
         checks++;
         if (wr_q[k] !== exp_write(cur_p1, cur_p2, k)) begin errors++; $display("FAIL midrst_write%0d: got %h expected %h", k, wr_q[k], exp_write(cur_p1, cur_p2, k)); end
      end
   endtask

   task automatic test_wr3();
      int          busy_cnt = 0;
      int          run = 0;
      int          sv = 0;
      logic        prev = 1'b1;
      logic [19:0] c3;
      logic [19:0] w3[$];
      int          l3[$];
      repeat (60) @(negedge clk);
      if (cur_p1 == 15) cur_p2 = (cur_p2 + 1) % 16;
      cur_p1 = 15;
      p1 = 4'd15; p2 = 4'(cur_p2);
      repeat (50) begin
         @(posedge clk); #1;
         if (busy3) busy_cnt++;
         if (!nwr3) begin
            if (prev) begin
               w3.push_back({addr3, data3});
               c3  = {addr3, data3};
               run = 1;
            end else begin
               run++;
               if ({addr3, data3} !== c3) sv++;
            end
         end else if (!prev) begin
            l3.push_back(run);
         end
         prev = nwr3;
      end
      checks++; if (busy_cnt !== 20) begin errors++; $display("FAIL wr3_busy: got %0d expected 20", busy_cnt); end
      checks++; if (w3.size() !== 4) begin errors++; $display("FAIL wr3_nwrites: got %0d expected 4", w3.size()); end
      for (int k = 0; k < 4 && k < w3.size(); k++) begin
         checks++;
         if (w3[k] !== exp_write(15, cur_p2, k)) begin errors++; $display("FAIL wr3_write%0d: got %h expected %h", k, w3[k], exp_write(15, cur_p2, k)); end
      end
      checks++; if (l3.size() !== 4) begin errors++; $display("FAIL wr3_npulses: got %0d expected 4", l3.size()); end
      foreach (l3[k]) begin
         checks++; if (l3[k] !== 3) begin errors++; $display("FAIL wr3_pulse%0d: got %0d expected 3", k, l3[k]); end
      end
      checks++; if (sv !== 0) begin errors++; $display("FAIL wr3_stability: got %0d expected 0", sv); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_p1_12();
      test_random();
      test_change_during_busy();
      test_refresh();
      test_reset_mid();
      test_wr3();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
